// File: rtl/tx_slot_pkg.sv
// Shared definitions for the TX slot ring writer: record geometry, FSM encoding
// and the record-size helper that the sender side can reuse.
package tx_slot_pkg;

  localparam int MAX_LEN   = 1518;
  localparam int HDR_WORDS = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_WRITE,
    ST_DROP,
    ST_COMMIT
  } slot_state_t;

  // Header words plus the payload rounded up to whole 16-bit words.
  function automatic logic [14:0] words_needed(input logic [15:0] len);
    return 15'(HDR_WORDS) + len[15:1] + {14'd0, len[0]};
  endfunction

endpackage

// File: rtl/tx_slot_rr_arb.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// requester that did not own the ring last.
module tx_slot_rr_arb (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_grant ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/tx_slot_writer.sv
// Arbitrates two record streams onto the TX slot ring and publishes the write
// pointer only after a complete, well-formed record has landed in memory.
//
// state     | meaning
// ST_IDLE   | no owner; pick a requester, snapshot the committed pointer
// ST_LEN    | hold the length word, wait for enough free space or reject
// ST_WRITE  | stream record words into the ring
// ST_DROP   | swallow the rest of a rejected record
// ST_COMMIT | publish the new write pointer, release the ring
module tx_slot_writer
  import tx_slot_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic [13:0] slot_tx_eth_addr,
  output logic [15:0] slot_tx_eth_data,
  output logic [1:0]  slot_tx_eth_byte_en,
  output logic        slot_tx_eth_wr_en,
  output logic        slot_tx_eth_en,
  input  logic [13:0] mem_rd_ptr,
  output logic [13:0] mem_wr_ptr,
  output logic [1:0]  grant,
  output logic [15:0] drop_count
);

  slot_state_t r_state, w_state_nxt;
  logic [1:0]  r_grant;
  logic        r_last_grant;
  logic [13:0] r_wr_addr;
  logic [13:0] r_mem_wr_ptr;
  logic [14:0] r_count;
  logic [14:0] r_need;
  logic [15:0] r_drop_count;
  logic        r_wr_en;
  logic [13:0] r_out_addr;
  logic [15:0] r_out_data;

  logic [1:0]  w_req;
  logic [1:0]  w_pick;
  logic        w_sel_valid;
  logic [15:0] w_sel_data;
  logic        w_sel_last;
  logic [14:0] w_need;
  logic [14:0] w_cnt_inc;
  logic [13:0] w_free;
  logic        w_len_bad;
  logic        w_ready;
  logic        w_hs;
  logic        w_drop_inc;

  assign w_req       = {req1_valid, req0_valid};
  assign w_sel_valid = r_grant[1] ? req1_valid : (r_grant[0] & req0_valid);
  assign w_sel_data  = r_grant[1] ? req1_data  : req0_data;
  assign w_sel_last  = r_grant[1] ? req1_last  : req0_last;
  assign w_need      = words_needed(w_sel_data);
  assign w_cnt_inc   = r_count + 15'd1;
  assign w_free      = mem_rd_ptr - r_mem_wr_ptr - 14'd1;
  assign w_len_bad   = (w_sel_data == 16'd0) || (w_sel_data > 16'(MAX_LEN));
  assign w_hs        = w_ready & w_sel_valid;

  tx_slot_rr_arb u_arb (
    .req        (w_req),
    .last_grant (r_last_grant),
    .pick       (w_pick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_drop_inc  = 1'b0;
    case (r_state)
      ST_IDLE: if (|w_req) w_state_nxt = ST_LEN;
      ST_LEN: begin
        if (w_sel_valid) begin
          if (w_len_bad)                     w_state_nxt = ST_DROP;
          else if ({1'b0, w_free} >= w_need) w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_ready = 1'b1;
        if (w_sel_valid) begin
          if (w_sel_last) begin
            if (w_cnt_inc == r_need) begin
              w_state_nxt = ST_COMMIT;
            end else begin
              // short record: leave the pointer alone so it never becomes visible
              w_state_nxt = ST_IDLE;
              w_drop_inc  = 1'b1;
            end
          end else if (w_cnt_inc == r_need) begin
            w_state_nxt = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        w_ready = 1'b1;
        if (w_sel_valid && w_sel_last) begin
          w_state_nxt = ST_IDLE;
          w_drop_inc  = 1'b1;
        end
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= 2'b00;
      r_last_grant <= 1'b1;
      r_wr_addr    <= '0;
      r_mem_wr_ptr <= '0;
      r_count      <= '0;
      r_need       <= '0;
      r_drop_count <= '0;
      r_wr_en      <= 1'b0;
      r_out_addr   <= '0;
      r_out_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_hs && (r_state == ST_WRITE);
      if (w_hs && (r_state == ST_WRITE)) begin
        r_out_addr <= r_wr_addr;
        r_out_data <= w_sel_data;
        r_wr_addr  <= r_wr_addr + 14'd1;
        r_count    <= w_cnt_inc;
      end
      if (w_drop_inc && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_grant   <= w_pick;
            r_wr_addr <= r_mem_wr_ptr;
            r_count   <= '0;
          end
        end
        ST_LEN: if (w_sel_valid) r_need <= w_need;
        ST_WRITE, ST_DROP: if (w_state_nxt == ST_IDLE) r_grant <= 2'b00;
        ST_COMMIT: begin
          r_mem_wr_ptr <= r_wr_addr;
          r_last_grant <= r_grant[1];
          r_grant      <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready          = w_ready & r_grant[0];
  assign req1_ready          = w_ready & r_grant[1];
  assign slot_tx_eth_addr    = r_out_addr;
  assign slot_tx_eth_data    = r_out_data;
  assign slot_tx_eth_wr_en   = r_wr_en;
  assign slot_tx_eth_en      = r_wr_en;
  assign slot_tx_eth_byte_en = {2{r_wr_en}};
  assign mem_wr_ptr          = r_mem_wr_ptr;
  assign grant               = r_grant;
  assign drop_count          = r_drop_count;

endmodule
